// File: rtl/cpu_decode.sv
// cpu_decode: instruction decode stage sitting behind the fetch FIFO.
// Classifies each {opcode, operand} pair by Moxie instruction form, extracts
// register indices and the immediate, tracks the architectural PC and
// presents a registered packet to execute. Back-pressure to fetch is
// combinational; a flush from execute discards the incoming instruction.
module cpu_decode #(
  parameter logic [31:0] BOOT_ADDRESS = 32'h00001000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [15:0] opcode_i,
  input  logic [31:0] operand_i,
  input  logic        valid_i,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic [31:0] flush_pc_i,
  input  logic        ex_load_i,
  input  logic [3:0]  ex_dest_i,
  output logic        stall_o,
  output logic        valid_o,
  output logic [7:0]  op_o,
  output logic [3:0]  reg_a_o,
  output logic [3:0]  reg_b_o,
  output logic [31:0] imm_o,
  output logic [31:0] pc_o,
  output logic        long_o,
  output logic        illegal_o
);

  // Decoded view of the instruction currently offered by fetch.
  typedef struct packed {
    logic [7:0]  op;
    logic [3:0]  reg_a;
    logic [3:0]  reg_b;
    logic [31:0] imm;
    logic        long_form;
    logic        illegal;
    logic        reads_a;
    logic        reads_b;
  } dec_t;

  dec_t        dec;
  logic        hazard;
  logic        accept;
  logic [31:0] pc_next;

  // Combinational decode of the incoming halfword by its form bits.
  always_comb begin
    // NOTE: every field gets a default before the case so no path leaves a
    // variable unassigned, which would otherwise infer a latch.
    dec = '0;
    case (opcode_i[15:14])
      2'b10: begin
        dec.op      = {6'b100000, opcode_i[13:12]};
        dec.reg_a   = opcode_i[11:8];
        dec.imm     = {24'h000000, opcode_i[7:0]};
        dec.reads_a = 1'b1;
      end
      2'b11: begin
        // Branch offset is counted in halfwords; shift to a byte offset.
        dec.op  = {4'hC, opcode_i[13:10]};
        dec.imm = {{21{opcode_i[9]}}, opcode_i[9:0], 1'b0};
      end
      default: begin
        dec.op      = {1'b0, opcode_i[14:8]};
        dec.reg_a   = opcode_i[7:4];
        dec.reg_b   = opcode_i[3:0];
        dec.reads_a = 1'b1;
        dec.reads_b = 1'b1;
        // Upper half of the form-1 opcode space is undefined; execute traps.
        dec.illegal = opcode_i[14];
        case (opcode_i[14:8])
          7'h01, 7'h03, 7'h08, 7'h09, 7'h0C, 7'h0D, 7'h1A, 7'h1B, 7'h1D,
          7'h1F, 7'h20, 7'h22, 7'h24, 7'h36, 7'h37, 7'h38, 7'h39:
            dec.long_form = 1'b1;
          default:
            dec.long_form = 1'b0;
        endcase
        dec.imm = dec.long_form ? operand_i : 32'h0;
      end
    endcase
  end

  // Load-use detection and handshake with fetch.
  always_comb begin
    hazard = valid_i & ex_load_i & valid_o &
             ((dec.reads_a & (ex_dest_i == dec.reg_a)) |
              (dec.reads_b & (ex_dest_i == dec.reg_b)));
    stall_o = (stall_i | hazard) & ~flush_i;
    accept  = valid_i & ~stall_o & ~flush_i;
  end

  // Packet and PC registers: reset > flush > stall > hazard bubble > accept.
  always_ff @(posedge clk_i) begin
    // NOTE: state is updated with non-blocking assignments so every register
    // sees the pre-edge values of the others, independent of statement order.
    if (rst_i) begin
      valid_o   <= 1'b0;
      op_o      <= '0;
      reg_a_o   <= '0;
      reg_b_o   <= '0;
      imm_o     <= '0;
      pc_o      <= BOOT_ADDRESS;
      long_o    <= 1'b0;
      illegal_o <= 1'b0;
      pc_next   <= BOOT_ADDRESS;
    end else if (flush_i) begin
      valid_o <= 1'b0;
      pc_next <= flush_pc_i;
    end else if (!stall_i) begin
      // With stall_i low, the only reasons not to accept are a hazard or an
      // empty input; both leave a bubble and keep pc_next.
      if (accept) begin
        valid_o   <= 1'b1;
        op_o      <= dec.op;
        reg_a_o   <= dec.reg_a;
        reg_b_o   <= dec.reg_b;
        imm_o     <= dec.imm;
        pc_o      <= pc_next;
        long_o    <= dec.long_form;
        illegal_o <= dec.illegal;
        pc_next   <= pc_next + (dec.long_form ? 32'd6 : 32'd2);
      end else begin
        valid_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cpu_decode.sv
// tb_cpu_decode: scoreboard bench for cpu_decode. A driver issues directed
// then random instructions and pushes expected packets from a behavioural
// reference model; a monitor pops and compares whenever a new packet appears.
module tb_cpu_decode;

  localparam logic [31:0] BOOT = 32'h00001000;
  localparam logic [7:0] LONG_OPS [17] = '{
    8'h01, 8'h03, 8'h08, 8'h09, 8'h0C, 8'h0D, 8'h1A, 8'h1B, 8'h1D,
    8'h1F, 8'h20, 8'h22, 8'h24, 8'h36, 8'h37, 8'h38, 8'h39};

  logic        clk_i = 1'b0;
  logic        rst_i, valid_i, stall_i, flush_i, ex_load_i;
  logic [15:0] opcode_i;
  logic [31:0] operand_i, flush_pc_i;
  logic [3:0]  ex_dest_i;
  logic        stall_o, valid_o, long_o, illegal_o;
  logic [7:0]  op_o;
  logic [3:0]  reg_a_o, reg_b_o;
  logic [31:0] imm_o, pc_o;

  always #5 clk_i = ~clk_i;

  cpu_decode dut (
    .clk_i(clk_i), .rst_i(rst_i), .opcode_i(opcode_i), .operand_i(operand_i),
    .valid_i(valid_i), .stall_i(stall_i), .flush_i(flush_i),
    .flush_pc_i(flush_pc_i), .ex_load_i(ex_load_i), .ex_dest_i(ex_dest_i),
    .stall_o(stall_o), .valid_o(valid_o), .op_o(op_o), .reg_a_o(reg_a_o),
    .reg_b_o(reg_b_o), .imm_o(imm_o), .pc_o(pc_o), .long_o(long_o),
    .illegal_o(illegal_o)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [7:0]  op;
    logic [3:0]  a;
    logic [3:0]  b;
    logic [31:0] imm;
    bit          lng;
    bit          ill;
    bit          rd_a;
    bit          rd_b;
    logic [31:0] pc;
  } exp_t;

  exp_t        sb[$];
  bit          m_valid;
  logic [31:0] m_pc_next;

  // Reference decode written from the form rules with plain arithmetic.
  function automatic exp_t ref_decode(input logic [15:0] opc,
                                      input logic [31:0] opr);
    exp_t        e;
    int unsigned u;
    int          off;
    u = opc;
    e.op = 0; e.a = 0; e.b = 0; e.imm = 0; e.lng = 0; e.ill = 0;
    e.rd_a = 0; e.rd_b = 0; e.pc = 0;
    if ((u >> 14) < 2) begin
      e.op = 8'(u >> 8);
      e.a  = 4'((u >> 4) % 16);
      e.b  = 4'(u % 16);
      foreach (LONG_OPS[i]) if (LONG_OPS[i] == e.op) e.lng = 1;
      e.imm  = e.lng ? opr : 32'h0;
      e.ill  = (e.op >= 8'h40);
      e.rd_a = 1;
      e.rd_b = 1;
    end else if ((u >> 14) == 2) begin
      e.op   = 8'(32'h80 + ((u >> 12) % 4));
      e.a    = 4'((u >> 8) % 16);
      e.imm  = u % 256;
      e.rd_a = 1;
    end else begin
      e.op = 8'(32'hC0 + ((u >> 10) % 16));
      off  = int'(u % 1024) * 2;
      if (off >= 1024) off -= 2048;
      e.imm = 32'(off);
    end
    return e;
  endfunction

  // One cycle of stimulus: drive, check the handshake, advance the model.
  task automatic step(input bit rst, input bit v, input logic [15:0] opc,
                      input logic [31:0] opr, input bit st, input bit fl,
                      input logic [31:0] fpc, input bit ld,
                      input logic [3:0] dst, output bit stalled,
                      output bit hz);
    exp_t e;
    bit   exp_st;
    rst_i = rst; valid_i = v; opcode_i = opc; operand_i = opr;
    stall_i = st; flush_i = fl; flush_pc_i = fpc;
    ex_load_i = ld; ex_dest_i = dst;
    #1;
    e  = ref_decode(opc, opr);
    hz = v && ld && m_valid && ((e.rd_a && dst == e.a) || (e.rd_b && dst == e.b));
    exp_st = (st || hz) && !fl;
    check("stall_o", stall_o, exp_st);
    stalled = exp_st;
    if (rst) begin
      m_valid = 0; m_pc_next = BOOT;
    end else if (fl) begin
      m_valid = 0; m_pc_next = fpc;
    end else if (st) begin
      m_valid = m_valid;
    end else if (hz) begin
      m_valid = 0;
    end else if (v) begin
      e.pc = m_pc_next;
      sb.push_back(e);
      m_pc_next = m_pc_next + (e.lng ? 32'd6 : 32'd2);
      m_valid = 1;
    end else begin
      m_valid = 0;
    end
    @(posedge clk_i);
    #1;
  endtask

  // Monitor: reset values, hold during stall, and scoreboard pops.
  initial begin
    bit          p_rst, p_hold;
    exp_t        e;
    logic        s_valid, s_long, s_ill;
    logic [7:0]  s_op;
    logic [3:0]  s_a, s_b;
    logic [31:0] s_imm, s_pc;
    forever begin
      @(posedge clk_i);
      p_rst  = rst_i;
      p_hold = !rst_i && !flush_i && stall_i;
      @(negedge clk_i);
      if (p_rst) begin
        check("rst valid_o", valid_o, 0);
        check("rst op_o", op_o, 0);
        check("rst reg_a_o", reg_a_o, 0);
        check("rst reg_b_o", reg_b_o, 0);
        check("rst imm_o", imm_o, 0);
        check("rst pc_o", pc_o, BOOT);
        check("rst long_o", long_o, 0);
        check("rst illegal_o", illegal_o, 0);
      end else if (p_hold) begin
        check("hold valid_o", valid_o, s_valid);
        check("hold op_o", op_o, s_op);
        check("hold reg_a_o", reg_a_o, s_a);
        check("hold reg_b_o", reg_b_o, s_b);
        check("hold imm_o", imm_o, s_imm);
        check("hold pc_o", pc_o, s_pc);
        check("hold long_o", long_o, s_long);
        check("hold illegal_o", illegal_o, s_ill);
      end else if (valid_o === 1'b1) begin
        if (sb.size() == 0) begin
          check("spurious valid_o", valid_o, 0);
        end else begin
          e = sb.pop_front();
          check("pkt op_o", op_o, e.op);
          check("pkt reg_a_o", reg_a_o, e.a);
          check("pkt reg_b_o", reg_b_o, e.b);
          check("pkt imm_o", imm_o, e.imm);
          check("pkt pc_o", pc_o, e.pc);
          check("pkt long_o", long_o, e.lng);
          check("pkt illegal_o", illegal_o, e.ill);
        end
      end
      s_valid = valid_o; s_op = op_o; s_a = reg_a_o; s_b = reg_b_o;
      s_imm = imm_o; s_pc = pc_o; s_long = long_o; s_ill = illegal_o;
    end
  end

  // Driver: directed scenarios followed by constrained-random traffic.
  initial begin
    bit          s, h, prev_s, prev_h;
    bit          v, st, fl, ld, rst;
    logic [15:0] opc;
    logic [31:0] opr, fpc;
    logic [3:0]  dst;
    m_valid = 0; m_pc_next = BOOT;
    rst_i = 1; valid_i = 0; opcode_i = 0; operand_i = 0; stall_i = 0;
    flush_i = 0; flush_pc_i = 0; ex_load_i = 0; ex_dest_i = 0;
    #1;

    // Reset, NOPs, long form, form 2 and form 3.
    step(1, 0, 16'h0000, 0, 0, 0, 0, 0, 0, s, h);
    step(1, 0, 16'h0000, 0, 0, 0, 0, 0, 0, s, h);
    step(0, 1, 16'h0F00, 0, 0, 0, 0, 0, 0, s, h);
    step(0, 1, 16'h0F00, 0, 0, 0, 0, 0, 0, s, h);
    step(0, 1, 16'h0120, 32'hDEADBEEF, 0, 0, 0, 0, 0, s, h);
    step(0, 1, 16'h8A05, 32'h12345678, 0, 0, 0, 0, 0, s, h);
    step(0, 1, 16'hC3FF, 32'h12345678, 0, 0, 0, 0, 0, s, h);
    // Load-use: one bubble, then issued with the unchanged PC.
    step(0, 1, 16'h0530, 0, 0, 0, 0, 1, 4'd3, s, h);
    step(0, 1, 16'h0530, 0, 0, 0, 0, 0, 4'd3, s, h);
    // Stall hold for three cycles, then flush during the stall.
    for (int i = 0; i < 3; i++) step(0, 1, 16'h0F00, 0, 1, 0, 0, 0, 0, s, h);
    step(0, 1, 16'h0F00, 0, 1, 1, 32'h00002000, 0, 0, s, h);
    step(0, 1, 16'h0F00, 0, 0, 0, 0, 0, 0, s, h);
    // Illegal opcode, then PC wrap.
    step(0, 1, 16'h4500, 0, 0, 0, 0, 0, 0, s, h);
    step(0, 0, 16'h0000, 0, 0, 1, 32'hFFFFFFFE, 0, 0, s, h);
    step(0, 1, 16'h0F00, 0, 0, 0, 0, 0, 0, s, h);
    step(0, 1, 16'h0F00, 0, 0, 0, 0, 0, 0, s, h);
    step(0, 0, 16'h0000, 0, 0, 0, 0, 0, 0, s, h);

    // Random traffic; fetch holds its instruction while stall_o is high.
    prev_s = 0; prev_h = 0; v = 0; opc = 0; opr = 0;
    for (int n = 0; n < 1500; n++) begin
      if (!prev_s) begin
        v   = ($urandom_range(0, 9) < 8);
        opc = 16'($urandom);
        opr = $urandom;
        if ($urandom_range(0, 2) == 0) opc[15:8] = LONG_OPS[$urandom_range(0, 16)];
      end
      st  = ($urandom_range(0, 4) == 0);
      fl  = ($urandom_range(0, 11) == 0);
      fpc = ($urandom_range(0, 3) == 0) ? (32'hFFFFFFF0 | ($urandom_range(0, 7) * 2))
                                        : ($urandom & 32'hFFFFFFFE);
      ld  = prev_h ? 1'b0 : ($urandom_range(0, 2) == 0);
      case ($urandom_range(0, 3))
        0: dst = opc[7:4];
        1: dst = opc[3:0];
        2: dst = opc[11:8];
        default: dst = 4'($urandom);
      endcase
      rst = ($urandom_range(0, 149) == 0);
      step(rst, v, opc, opr, st, fl, fpc, ld, dst, s, h);
      prev_s = s && !rst;
      prev_h = h && !rst && !fl && !st;
    end
    step(0, 0, 16'h0000, 0, 0, 0, 0, 0, 0, s, h);
    step(0, 0, 16'h0000, 0, 0, 0, 0, 0, 0, s, h);
    check("scoreboard drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
